miriscv_fetch_buffer_unit: RTL
==============================

# miriscv_fetch_buffer_unit

Parametrised instruction fetch unit with a prefetch FIFO, multiple outstanding memory requests and an optional static branch predictor. It replaces the single-register fetch stage: it sits between the instruction memory port and the decode stage. Memory latency is decoupled from decode stalls by buffering up to `FIFO_DEPTH` fetched instructions. Kills and predicted-taken branches redirect fetch and discard every stale in-flight response.

## Interface
- `XLEN`, 32: address/data width (from `miriscv_pkg`).
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum accepted-but-unanswered memory requests; 1..`FIFO_DEPTH`.
- `clk_i` in 1: clock, all logic on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `boot_addr_i` in XLEN: first fetch address after boot load.
- `cu_boot_addr_load_en_i` in 1: hold fetch idle; on deassertion start at `boot_addr_i`.
- `instr_req_o` out 1: request valid.
- `instr_addr_o` out XLEN: request address, word aligned.
- `instr_gnt_i` in 1: request accepted this cycle when `instr_req_o & instr_gnt_i`.
- `instr_rvalid_i` in 1: in-order response valid, ≥1 cycle after grant.
- `instr_rdata_i` in 32: response instruction.
- `cu_kill_f_i` in 1: redirect fetch to `cu_pc_bra_i`, flush buffer.
- `cu_pc_bra_i` in XLEN: redirect target.
- `d_ready_i` in 1: decode accepts head entry.
- `f_valid_o` out 1: head entry valid.
- `f_instr_o` out 32: head instruction (NOP 0x00000013 when invalid).
- `f_current_pc_o` out XLEN: PC of head instruction.
- `f_next_pc_o` out XLEN: predicted PC of the next instruction.
- `f_pred_taken_o` out 1: head was predicted taken.

## Operation
- FSM states: `BOOT` (reset state, no requests), `RUN`.
- `BOOT`→`RUN` in the first cycle `cu_boot_addr_load_en_i`=0; `fetch_pc` and `resp_pc` ← `boot_addr_i`.
- `RUN`→`BOOT` whenever `cu_boot_addr_load_en_i`=1: flush as for a kill.
- Issue: `instr_req_o` = `RUN` & ~`cu_kill_f_i` & (`outstanding` < `MAX_OUTSTANDING`) & (`outstanding` + `count` < `FIFO_DEPTH`). The credit rule guarantees every response has a slot; no response is dropped for lack of space.
- `instr_addr_o` = `fetch_pc`. On grant, `fetch_pc` += 4 and `outstanding`++.
- Response with `discard_cnt`=0: push {rdata, `resp_pc`, pred, next_pc}; `resp_pc` ← next_pc.
- Response with `discard_cnt`>0: drop it and decrement `discard_cnt`. `outstanding`-- on every response.
- Prediction (macro on): taken iff opcode = `OPCODE_BRANCH` and bit 31 = 1 (backward). Target = `resp_pc` + B-immediate, sign-extended.
- On a taken prediction, set `fetch_pc` and `resp_pc` to the target and `discard_cnt` ← `outstanding` − 1 (younger in-flight requests). No new request issues that cycle.
- Kill: FIFO emptied, `fetch_pc` and `resp_pc` ← `cu_pc_bra_i`. `discard_cnt` ← `outstanding` minus any response arriving the same cycle, and that response is dropped. Kill wins over push, pop, prediction and grant (`instr_req_o` is 0 during the kill).
- Pop when `f_valid_o & d_ready_i`. Push and pop in the same cycle leave `count` unchanged. A push into an empty FIFO is visible on the next cycle.
- Widths: `count`, `outstanding` and `discard_cnt` are $clog2 of (max+1) bits. PC arithmetic is modulo 2^XLEN; wrap-around is silent.

## Timing
- Reset values: `instr_req_o`=0, `f_valid_o`=0, `f_instr_o`=0x00000013, `f_current_pc_o`/`f_next_pc_o`=0, `f_pred_taken_o`=0. State `BOOT`, all counters 0.
- Reset mid-operation discards every in-flight response.
- Boot deassert at cycle N → first request at N+1 with `boot_addr_i`.
- Redirect (kill or prediction) at cycle N → request to the new address at N+1.
- Response at cycle N → `f_valid_o` at N+1 when the FIFO was empty; no combinational memory-to-decode path.
- Full throughput of 1 instr/cycle when `MAX_OUTSTANDING` ≥ memory latency + 1 and `d_ready_i`=1.

## Configuration
- `MIRISCV_FETCH_BRANCH_PRED_EN` defined: static backward-taken predictor active as above.
- Not defined: no predictor logic; `f_pred_taken_o`=0, next_pc = pc+4, redirects only by kill.

## Structure
- `miriscv_pkg`: `fetch_entry_t` struct {instr, pc, next_pc, pred_taken} and a `NOP_INSTR` constant (0x00000013). `OPCODE_BRANCH` comes from `miriscv_opcodes_pkg`.
- Sub-module `miriscv_fetch_fifo`: synchronous FIFO of `fetch_entry_t`, parameter `DEPTH`. Ports: push, pop, flush, count, full, empty, head. Same `clk_i`/`rst_i`.

## Test plan
- Boot: `boot_addr_i`=0x8000_0000, deassert load_en, 1-cycle memory → requests 0x80000000, 0x80000004, …; `f_current_pc_o` follows the same sequence, `f_next_pc_o` = pc+4.
- Backpressure: `d_ready_i`=0 for 10 cycles, `FIFO_DEPTH`=4 → exactly 4 responses buffered, `instr_req_o`=0 once `count`+`outstanding`=4. Release → in-order drain with no loss.
- Kill with 2 outstanding: `cu_pc_bra_i`=0x100 → FIFO empty next cycle, both stale responses dropped, next valid `f_current_pc_o`=0x100.
- Predictor (macro on): at 0x200, fetch `beq` with imm −8 (0xFE000CE3) → `f_pred_taken_o`=1, `f_next_pc_o`=0x1F8, the 0x204 response discarded, next head PC=0x1F8.
- Predictor off: same stimulus → `f_pred_taken_o`=0, `f_next_pc_o`=0x204.
- Kill in the same cycle as `instr_rvalid_i` and `d_ready_i` → response dropped, `discard_cnt` excludes it, `f_valid_o`=0 next cycle.

Source files
------------

// File: rtl/miriscv_opcodes_pkg.sv
// RISC-V base opcodes needed by the fetch stage.
package miriscv_opcodes_pkg;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

endpackage

// File: rtl/miriscv_pkg.sv
// Shared core types: XLEN, fetch buffer entry, fetch FSM states and immediate helpers.
package miriscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] next_pc;
        logic            pred_taken;
    } fetch_entry_t;

    typedef enum logic {BOOT, RUN} fetch_state_e;

    // Sign-extended B-type immediate; bit 31 doubles as the sign / backward flag.
    function automatic logic [XLEN-1:0] b_imm(input logic [31:0] instr);
        return {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/miriscv_fetch_fifo.sv
// Prefetch buffer: circular FIFO of fetch entries with synchronous flush.
module miriscv_fetch_fifo
    import miriscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  fetch_entry_t               data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o,
    output fetch_entry_t               head_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/miriscv_fetch_buffer_unit.sv
// Instruction fetch with prefetch FIFO and multiple outstanding requests.
// Optional static backward-taken predictor: define MIRISCV_FETCH_BRANCH_PRED_EN.
module miriscv_fetch_buffer_unit
    import miriscv_pkg::*;
    import miriscv_opcodes_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] boot_addr_i,
    input  logic            cu_boot_addr_load_en_i,
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_gnt_i,
    input  logic            instr_rvalid_i,
    input  logic [31:0]     instr_rdata_i,
    input  logic            cu_kill_f_i,
    input  logic [XLEN-1:0] cu_pc_bra_i,
    input  logic            d_ready_i,
    output logic            f_valid_o,
    output logic [31:0]     f_instr_o,
    output logic [XLEN-1:0] f_current_pc_o,
    output logic [XLEN-1:0] f_next_pc_o,
    output logic            f_pred_taken_o
);

    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [OW-1:0]   out_q, out_d, discard_q, discard_d;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    fifo_head, push_entry;
    logic            run, flush, rsp, push, pop, grant, pred_taken;
    logic [XLEN-1:0] pred_next;

    assign run   = (state_q == RUN);
    assign flush = run & (cu_kill_f_i | cu_boot_addr_load_en_i);
    // A response with nothing outstanding is left over from before a reset.
    assign rsp   = instr_rvalid_i & (out_q != '0);
    assign push  = rsp & run & ~flush & (discard_q == '0);

`ifdef MIRISCV_FETCH_BRANCH_PRED_EN
    assign pred_taken = push & (instr_rdata_i[6:0] == OPCODE_BRANCH) & instr_rdata_i[31];
    assign pred_next  = pred_taken ? resp_pc_q + b_imm(instr_rdata_i) : resp_pc_q + XLEN'(4);
`else
    assign pred_taken = 1'b0;
    assign pred_next  = resp_pc_q + XLEN'(4);
`endif

    assign instr_req_o  = run & ~cu_boot_addr_load_en_i & ~cu_kill_f_i & ~pred_taken & ~fifo_full
                        & (out_q < OW'(MAX_OUTSTANDING))
                        & ((32'(out_q) + 32'(fifo_count)) < 32'(FIFO_DEPTH));
    assign instr_addr_o = fetch_pc_q;
    assign grant        = instr_req_o & instr_gnt_i;
    assign pop          = ~fifo_empty & d_ready_i & ~flush;

    assign push_entry = '{instr: instr_rdata_i, pc: resp_pc_q, next_pc: pred_next, pred_taken: pred_taken};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q + OW'(grant) - OW'(rsp);
        discard_d  = discard_q;
        if (rsp && discard_q != '0) discard_d = discard_q - OW'(1);
        if (grant) fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (push)  resp_pc_d  = pred_next;
        // Everything issued after the predicted branch is on the wrong path.
        if (pred_taken) begin
            fetch_pc_d = pred_next;
            discard_d  = out_q - OW'(1);
        end
        if (flush) begin
            fetch_pc_d = cu_pc_bra_i;
            resp_pc_d  = cu_pc_bra_i;
            discard_d  = out_q - OW'(rsp);
            if (cu_boot_addr_load_en_i) state_d = BOOT;
        end
        if (!run && !cu_boot_addr_load_en_i) begin
            state_d    = RUN;
            fetch_pc_d = boot_addr_i;
            resp_pc_d  = boot_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= BOOT;
            fetch_pc_q <= '0;
            resp_pc_q  <= '0;
            out_q      <= '0;
            discard_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            discard_q  <= discard_d;
        end
    end

    miriscv_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    assign f_valid_o      = ~fifo_empty;
    assign f_instr_o      = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign f_current_pc_o = fifo_empty ? '0 : fifo_head.pc;
    assign f_next_pc_o    = fifo_empty ? '0 : fifo_head.next_pc;
    assign f_pred_taken_o = ~fifo_empty & fifo_head.pred_taken;

endmodule
